// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time-of-day source: set-mode state
// encodings, BCD field limits, time bus layout and BCD step helpers.
package rtc_pkg;

  // Set-mode state; also driven out directly as set_field.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } state_t;

  localparam int unsigned BCD_W  = 8;
  localparam int unsigned TIME_W = 33;

  // Two-digit BCD wrap limits.
  localparam logic [BCD_W-1:0] HH_MAX = 8'h23;
  localparam logic [BCD_W-1:0] MS_MAX = 8'h59;

  // Field offsets inside time_now_data; bits above HH stay zero.
  localparam int unsigned HH_LSB = 16;
  localparam int unsigned MM_LSB = 8;
  localparam int unsigned SS_LSB = 0;

  // Two-digit BCD increment, wrapping max -> 00.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max);
    if (v == max)
      bcd_inc = '0;
    else if (v[3:0] == 4'h9)
      bcd_inc = {v[7:4] + 4'd1, 4'h0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement, wrapping 00 -> max.
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max);
    if (v == '0)
      bcd_dec = max;
    else if (v[3:0] == 4'h0)
      bcd_dec = {v[7:4] - 4'd1, 4'h9};
    else
      bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/rtc_time_source_bcd_field_counter.sv
// Two-digit BCD up/down counter for one time field (hh, mm or ss).
// Ports:
//   clk_50M, s_rst_n : clock, synchronous active-low reset (loads INIT)
//   inc, dec         : edit step up/down; both together do nothing
//   carry_in         : run-time advance from the lower field or the 1 Hz tick
//   value            : current BCD value
//   carry_out_c      : combinational, high when carry_in wraps MAX -> 00
module bcd_field_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX  = 8'h59,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic             clk_50M,
  input  logic             s_rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  output logic [BCD_W-1:0] value,
  output logic             carry_out_c
);

  logic up_c;
  logic dn_c;

  // Only the run-time advance ripples onward; edits never carry.
  always_comb begin
    up_c        = (inc | carry_in) & ~dec;
    dn_c        = dec & ~inc & ~carry_in;
    carry_out_c = carry_in & (value == MAX);
  end

  // Field register.
  always_ff @(posedge clk_50M) begin
    if (!s_rst_n)
      value <= INIT;
    else if (up_c)
      value <= bcd_inc(value, MAX);
    else if (dn_c)
      value <= bcd_dec(value, MAX);
  end

endmodule

// File: rtl/rtc_time_source.sv
// 24 h BCD wall clock with key-driven set mode and edit-field blink flag.
// Ports:
//   clk_50M, s_rst_n   : clock, synchronous active-low reset
//   key_mode           : pulse, steps RUN -> HOUR -> MIN -> SEC -> RUN
//   key_up, key_down   : pulse, edit the selected field with wrap
//   time_now_data[32:0]: {9'd0, hh, mm, ss} packed BCD
//   sec_tick           : one-cycle pulse when seconds advance in RUN
//   set_field[1:0]     : 0=RUN, 1=HOUR, 2=MIN, 3=SEC
//   blink              : half-second toggle in set states, 1 in RUN
module rtc_time_source
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter logic [23:0] INIT_TIME = 24'h08_00_00
) (
  input  logic              clk_50M,
  input  logic              s_rst_n,
  input  logic              key_mode,
  input  logic              key_up,
  input  logic              key_down,
  output logic [TIME_W-1:0] time_now_data,
  output logic              sec_tick,
  output logic [1:0]        set_field,
  output logic              blink
);

  localparam int unsigned PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HALF_HZ = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned BLK_W   = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);
  localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(HALF_HZ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PRE_W-1:0] presc;
  logic [BLK_W-1:0] blk_cnt;
  logic             presc_tc_c;
  logic             tick_c;
  logic             presc_clr_c;
  logic             enter_set_c;
  logic             edit_up_c;
  logic             edit_dn_c;
  logic             hh_inc_c, hh_dec_c;
  logic             mm_inc_c, mm_dec_c;
  logic             ss_inc_c, ss_dec_c;
  logic [BCD_W-1:0] hh_q, mm_q, ss_q;
  logic             ss_carry_c, mm_carry_c, hh_carry_c;

  assign presc_tc_c = (presc == PRE_TC);
  assign set_field  = state;

  // State register.
  always_ff @(posedge clk_50M) begin
    if (!s_rst_n)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  // Next state, tick qualification and edit decode. key_mode always wins,
  // which also suppresses a tick landing on the RUN -> HOUR edge.
  always_comb begin
    state_nxt   = state;
    tick_c      = 1'b0;
    presc_clr_c = 1'b0;
    edit_up_c   = 1'b0;
    edit_dn_c   = 1'b0;
    case (state)
      ST_RUN: begin
        if (key_mode) state_nxt = ST_HOUR;
        else          tick_c    = presc_tc_c;
      end
      ST_HOUR: if (key_mode) state_nxt = ST_MIN;
      ST_MIN:  if (key_mode) state_nxt = ST_SEC;
      ST_SEC: begin
        if (key_mode) begin
          state_nxt   = ST_RUN;
          presc_clr_c = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if ((state != ST_RUN) && !key_mode) begin
      edit_up_c = key_up & ~key_down;
      edit_dn_c = key_down & ~key_up;
    end
    enter_set_c = key_mode & (state_nxt != ST_RUN);
    hh_inc_c    = edit_up_c & (state == ST_HOUR);
    hh_dec_c    = edit_dn_c & (state == ST_HOUR);
    mm_inc_c    = edit_up_c & (state == ST_MIN);
    mm_dec_c    = edit_dn_c & (state == ST_MIN);
    ss_inc_c    = edit_up_c & (state == ST_SEC);
    ss_dec_c    = edit_dn_c & (state == ST_SEC);
  end

  // 1 Hz prescaler; cleared on set-mode exit so the first tick is a full second out.
  always_ff @(posedge clk_50M) begin
    if (!s_rst_n)
      presc <= '0;
    else if (presc_clr_c || presc_tc_c)
      presc <= '0;
    else
      presc <= presc + PRE_W'(1);
  end

  // Registered tick, coincident with the time update.
  always_ff @(posedge clk_50M) begin
    if (!s_rst_n)
      sec_tick <= 1'b0;
    else
      sec_tick <= tick_c;
  end

  // Half-second blink; restarts low on every entry into a set state.
  always_ff @(posedge clk_50M) begin
    if (!s_rst_n) begin
      blink   <= 1'b1;
      blk_cnt <= '0;
    end else if (state_nxt == ST_RUN) begin
      blink   <= 1'b1;
      blk_cnt <= '0;
    end else if (enter_set_c) begin
      blink   <= 1'b0;
      blk_cnt <= '0;
    end else if (blk_cnt == BLK_TC) begin
      blink   <= ~blink;
      blk_cnt <= '0;
    end else begin
      blk_cnt <= blk_cnt + BLK_W'(1);
    end
  end

  // Seconds, minutes, hours; carry ripples within one cycle.
  bcd_field_counter #(.MAX(MS_MAX), .INIT(INIT_TIME[7:0])) u_ss (
    .clk_50M    (clk_50M),
    .s_rst_n    (s_rst_n),
    .inc        (ss_inc_c),
    .dec        (ss_dec_c),
    .carry_in   (tick_c),
    .value      (ss_q),
    .carry_out_c(ss_carry_c)
  );

  bcd_field_counter #(.MAX(MS_MAX), .INIT(INIT_TIME[15:8])) u_mm (
    .clk_50M    (clk_50M),
    .s_rst_n    (s_rst_n),
    .inc        (mm_inc_c),
    .dec        (mm_dec_c),
    .carry_in   (ss_carry_c),
    .value      (mm_q),
    .carry_out_c(mm_carry_c)
  );

  bcd_field_counter #(.MAX(HH_MAX), .INIT(INIT_TIME[23:16])) u_hh (
    .clk_50M    (clk_50M),
    .s_rst_n    (s_rst_n),
    .inc        (hh_inc_c),
    .dec        (hh_dec_c),
    .carry_in   (mm_carry_c),
    .value      (hh_q),
    .carry_out_c(hh_carry_c)
  );

  // Midnight wrap needs no further action; hours simply return to 00.
  logic unused_c;
  assign unused_c = hh_carry_c;

  // Time bus assembly; reserved upper bits held at zero.
  always_comb begin
    time_now_data                   = '0;
    time_now_data[HH_LSB +: BCD_W]  = hh_q;
    time_now_data[MM_LSB +: BCD_W]  = mm_q;
    time_now_data[SS_LSB +: BCD_W]  = ss_q;
  end

endmodule

// File: tb/tb_rtc_time_source.sv
// Bench for rtc_time_source with CLK_HZ=10: per-cycle scoreboard against a
// decimal reference model, a table of set-mode edit vectors, and hand-written
// sequences for tick spacing, blink cadence, tick/mode collision and reset.
module tb_rtc_time_source;

  localparam int HZ = 10;

  logic        clk_50M = 1'b0;
  logic        s_rst_n;
  logic        key_mode;
  logic        key_up;
  logic        key_down;
  logic [32:0] time_now_data;
  logic        sec_tick;
  logic [1:0]  set_field;
  logic        blink;

  rtc_time_source #(.CLK_HZ(HZ), .INIT_TIME(24'h08_00_00)) dut (
    .clk_50M      (clk_50M),
    .s_rst_n      (s_rst_n),
    .key_mode     (key_mode),
    .key_up       (key_up),
    .key_down     (key_down),
    .time_now_data(time_now_data),
    .sec_tick     (sec_tick),
    .set_field    (set_field),
    .blink        (blink)
  );

  always #5 clk_50M = ~clk_50M;

  typedef struct packed {
    logic [32:0] t;
    logic        tick;
    logic [1:0]  f;
    logic        b;
  } obs_t;

  typedef struct {
    logic        km;
    logic        ku;
    logic        kd;
    logic [1:0]  f;
    logic [23:0] t;
  } vec_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model in plain decimal.
  int   m_st, m_h, m_m, m_s, m_presc, m_bcnt;
  logic m_tick, m_blink;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic void model_step(input logic rst, input logic km,
                                     input logic ku, input logic kd);
    int   nst;
    int   d;
    logic tc;
    logic tick;
    if (!rst) begin
      m_st = 0; m_h = 8; m_m = 0; m_s = 0;
      m_presc = 0; m_tick = 1'b0; m_blink = 1'b1; m_bcnt = 0;
      return;
    end
    tc   = (m_presc == HZ - 1);
    tick = (m_st == 0) && !km && tc;
    nst  = km ? (m_st + 1) % 4 : m_st;
    if ((m_st == 3 && km) || tc) m_presc = 0;
    else                         m_presc = m_presc + 1;
    if (tick) begin
      m_s = m_s + 1;
      if (m_s == 60) begin
        m_s = 0;
        m_m = m_m + 1;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
        end
      end
    end else if (m_st != 0 && !km && (ku != kd)) begin
      d = ku ? 1 : -1;
      case (m_st)
        1: m_h = (m_h + d + 24) % 24;
        2: m_m = (m_m + d + 60) % 60;
        default: m_s = (m_s + d + 60) % 60;
      endcase
    end
    if (nst == 0) begin
      m_blink = 1'b1; m_bcnt = 0;
    end else if (km) begin
      m_blink = 1'b0; m_bcnt = 0;
    end else if (m_bcnt == HZ / 2 - 1) begin
      m_blink = ~m_blink; m_bcnt = 0;
    end else begin
      m_bcnt = m_bcnt + 1;
    end
    m_tick = tick;
    m_st   = nst;
  endfunction

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc%0d: got %h want %h", name, cycle, got, want);
    end
  endtask

  // One clock: drive keys, predict, then compare the full output set.
  task automatic cyc(input logic rst, input logic k_m, input logic k_u, input logic k_d);
    obs_t e;
    obs_t a;
    s_rst_n  = rst;
    key_mode = k_m;
    key_up   = k_u;
    key_down = k_d;
    model_step(rst, k_m, k_u, k_d);
    e = {9'd0, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), m_tick, 2'(m_st), m_blink};
    exp_q.push_back(e);
    @(posedge clk_50M);
    #1;
    cycle++;
    e = exp_q.pop_front();
    a = {time_now_data, sec_tick, set_field, blink};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cyc%0d: got t=%h tick=%b f=%0d b=%b want t=%h tick=%b f=%0d b=%b",
               cycle, a.t, a.tick, a.f, a.b, e.t, e.tick, e.f, e.b);
    end
  endtask

  // Idle until sec_tick, bounded; returns cycles waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!sec_tick && n < 20);
  endtask

  task automatic idle_until_presc(input int p);
    for (int i = 0; i < 2 * HZ && m_presc != p; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[19];

  initial begin
    int n;
    int ntick;

    // Edit sequence driving 08:00:00 to 23:59:58 with wrap and collision cases.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 24'h08_00_00};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 2'd1, {to_bcd(8 - i), 16'h0000}};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 24'h23_00_00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 24'h23_00_00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 24'h23_59_00};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd2, 24'h23_00_00};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 24'h23_59_00};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd2, 24'h23_59_00};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd3, 24'h23_59_00};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 2'd3, 24'h23_59_59};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 2'd3, 24'h23_59_58};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h23_59_58};

    s_rst_n = 1'b0; key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_time",  time_now_data, 33'h0_08_00_00);
    chk("rst_field", 33'(set_field), 33'd0);
    chk("rst_blink", 33'(blink), 33'd1);
    chk("rst_tick",  33'(sec_tick), 33'd0);

    // Free run for 30 cycles: ticks on every 10th edge.
    ntick = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (sec_tick) begin
        ntick++;
        chk("tick_phase", 33'(i % HZ), 33'd0);
      end
    end
    chk("run30_ticks", 33'(ntick), 33'd3);
    chk("run30_time",  time_now_data, 33'h0_08_00_03);
    chk("upper_zero",  33'(time_now_data[32:24]), 33'd0);

    // Set-mode edit table from a clean reset.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      cyc(1'b1, vecs[i].km, vecs[i].ku, vecs[i].kd);
      chk($sformatf("vec%0d_field", i), 33'(set_field), 33'(vecs[i].f));
      chk($sformatf("vec%0d_time", i), time_now_data, {9'd0, vecs[i].t});
    end

    // First tick a full second after set-mode exit, then midnight roll-over.
    wait_tick(n);
    chk("exit_gap",   33'(n), 33'(HZ));
    chk("t_235959",   time_now_data, 33'h0_23_59_59);
    wait_tick(n);
    chk("wrap_gap",   33'(n), 33'(HZ));
    chk("t_midnight", time_now_data, 33'h0_00_00_00);
    chk("wrap_tick",  33'(sec_tick), 33'd1);

    // Terminal count colliding with RUN -> HOUR: no tick, time frozen.
    idle_until_presc(HZ - 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tc_mode_tick",  33'(sec_tick), 33'd0);
    chk("tc_mode_time",  time_now_data, 33'h0_00_00_00);
    chk("tc_mode_field", 33'(set_field), 33'd1);
    chk("tc_mode_blink", 33'(blink), 33'd0);

    // 50 cycles in HOUR: no ticks, blink toggles every 5 cycles.
    for (int k = 1; k <= 50; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("set_blink", 33'(blink), 33'((k / 5) % 2));
      chk("set_notick", 33'(sec_tick), 33'd0);
    end
    chk("set_frozen", time_now_data, 33'h0_00_00_00);

    // Reset mid-MIN with prescaler at 7 and a key pending.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("to_min", 33'(set_field), 33'd2);
    idle_until_presc(7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_field", 33'(set_field), 33'd0);
    chk("mid_rst_time",  time_now_data, 33'h0_08_00_00);
    chk("mid_rst_blink", 33'(blink), 33'd1);
    wait_tick(n);
    chk("mid_rst_gap",   33'(n), 33'(HZ));
    chk("mid_rst_t1",    time_now_data, 33'h0_08_00_01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1);
  end

endmodule
